// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned STARVE_W   = 4;   // holds STARVE_LIMIT up to 15

  // FSM states: IDLE grants; the *_RD states are the memory read-latency cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RD  = 2'd1,
    HOST_RD = 2'd2
  } arb_state_e;

  // Which requester owns the memory port in the current IDLE cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_HOST = 2'd2
  } gnt_src_e;

  // Saturating 16-bit increment for statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU, host and memory-side signals around the data-memory arbiter.
// Handshake: cpu_req is held until cpu_ready; host_req (and its fields) is held
// until host_gnt; host read data arrives with host_rvalid the cycle after grant.
interface dmem_arbiter_if import dmem_arb_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              cpu_ready;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_q,
    output cpu_rdata, cpu_stall, cpu_ready,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_wdata, mem_wren
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output mem_q,
    input  cpu_rdata, cpu_stall, cpu_ready,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_wdata, mem_wren
  );
endinterface

// File: rtl/dmem_arbiter_stats.sv
// Saturating usage counters for the arbiter: CPU stall cycles and host grants.
// Only present when DMEM_ARB_STATS_EN is defined.
`ifdef DMEM_ARB_STATS_EN
module dmem_arb_stats import dmem_arb_pkg::*; (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        host_gnt_i,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] host_cnt_o
);
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] host_cnt_q,  host_cnt_d;

  // Next-count: bump each counter on its event, stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_i    ? sat_inc16(stall_cnt_q) : stall_cnt_q;
    host_cnt_d  = host_gnt_i ? sat_inc16(host_cnt_q)  : host_cnt_q;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      host_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      host_cnt_q  <= host_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign host_cnt_o  = host_cnt_q;
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port synchronous data memory (registered address,
// 1-cycle read latency) between the core's lw/sw path and a host loader port.
// CPU has priority; a starvation counter lets the host win after STARVE_LIMIT
// waiting cycles. Optional macro DMEM_ARB_STATS_EN adds stat_stall_cnt and
// stat_host_cnt outputs.
module dmem_arbiter import dmem_arb_pkg::*; #(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus,
  output arb_state_e    dbg_state_o
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_stall_cnt,
  output logic [15:0]   stat_host_cnt
`endif
);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_LIMIT);
  localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

  arb_state_e        state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  gnt_src_e          gnt_src;
  logic              host_wins;
  logic              cpu_stall, cpu_ready, host_gnt, host_rvalid, mem_wren;
  logic [DATA_W-1:0] cpu_rdata, host_rdata;

  // Grant selection, next state and all handshake outputs. While reset is
  // high nothing is granted or completed, so a read in flight is dropped.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    gnt_src     = GNT_NONE;
    cpu_stall   = 1'b0;
    cpu_ready   = 1'b0;
    host_gnt    = 1'b0;
    host_rvalid = 1'b0;
    mem_wren    = 1'b0;
    cpu_rdata   = '0;
    host_rdata  = '0;
    host_wins   = bus.host_req && (!bus.cpu_req || (starve_q >= STARVE_LIM));

    if (!reset && state_q == IDLE) begin
      if (host_wins)        gnt_src = GNT_HOST;
      else if (bus.cpu_req) gnt_src = GNT_CPU;
    end

    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (gnt_src == GNT_HOST) begin
            host_gnt  = 1'b1;
            addr_d    = bus.host_addr;
            wdata_d   = bus.host_wdata;
            mem_wren  = bus.host_we;
            cpu_stall = bus.cpu_req;   // CPU lost this cycle
            if (!bus.host_we) state_d = HOST_RD;
          end else if (gnt_src == GNT_CPU) begin
            addr_d    = bus.cpu_addr;
            wdata_d   = bus.cpu_wdata;
            mem_wren  = bus.cpu_we;
            cpu_ready = bus.cpu_we;    // sw completes immediately
            cpu_stall = !bus.cpu_we;   // lw waits one cycle for mem_q
            if (!bus.cpu_we) state_d = CPU_RD;
          end
        end
        CPU_RD: begin
          cpu_rdata = bus.mem_q;
          cpu_ready = 1'b1;
          state_d   = IDLE;
        end
        HOST_RD: begin
          host_rvalid = 1'b1;
          host_rdata  = bus.mem_q;
          cpu_stall   = bus.cpu_req;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (host_gnt)                                      starve_d = '0;
    else if (bus.host_req && (starve_q != STARVE_MAX)) starve_d = starve_q + 1'b1;
    else                                               starve_d = starve_q;
  end

  // State, starvation counter and held memory address/data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // The memory registers its address, so the new address is presented
  // combinationally in the grant cycle and held afterwards.
  assign bus.mem_addr    = addr_d;
  assign bus.mem_wdata   = wdata_d;
  assign bus.mem_wren    = mem_wren;
  assign bus.cpu_rdata   = cpu_rdata;
  assign bus.cpu_stall   = cpu_stall;
  assign bus.cpu_ready   = cpu_ready;
  assign bus.host_gnt    = host_gnt;
  assign bus.host_rvalid = host_rvalid;
  assign bus.host_rdata  = host_rdata;
  assign dbg_state_o     = state_q;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_stats u_stats (
    .clock_i     (clock),
    .reset_i     (reset),
    .stall_i     (cpu_stall),
    .host_gnt_i  (host_gnt),
    .stall_cnt_o (stat_stall_cnt),
    .host_cnt_o  (stat_host_cnt)
  );
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: single-cycle grant vectors from IDLE
// plus hand-written multi-cycle sequences (read latency, starvation, reset).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clock;
  logic reset;
  arb_state_e dbg_state;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_cnt;
  logic [15:0] stat_host_cnt;
`endif

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .STARVE_LIMIT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_stall_cnt (stat_stall_cnt),
    .stat_host_cnt  (stat_host_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory model: registered address, 1-cycle read latency.
  logic [15:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  always @(posedge clock) begin
    if (bus.mem_wren) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_q <= mem[bus.mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic cpu_drive(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
  endtask

  task automatic host_drive(input logic we, input logic [7:0] addr, input logic [15:0] wd);
    bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [15:0] host_wdata;
    logic        exp_stall;
    logic        exp_ready;
    logic        exp_gnt;
    logic        exp_wren;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int gnt_cycle;

    vecs[0] = '{"idle",       1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
                1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000};
    vecs[1] = '{"cpu_sw",     1'b1, 1'b1, 8'h09, 16'h1234, 1'b0, 1'b0, 8'h00, 16'h0000,
                1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 16'h1234};
    vecs[2] = '{"cpu_lw",     1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000,
                1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 16'h0000};
    vecs[3] = '{"host_wr",    1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h03, 16'hBEEF,
                1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 16'hBEEF};
    vecs[4] = '{"host_rd",    1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h07, 16'h0000,
                1'b0, 1'b0, 1'b1, 1'b0, 8'h07, 16'h0000};
    vecs[5] = '{"both_lw_rd", 1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 8'h20, 16'h0000,
                1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 16'h0000};
    vecs[6] = '{"both_sw_wr", 1'b1, 1'b1, 8'h11, 16'hAAAA, 1'b1, 1'b1, 8'h22, 16'h5555,
                1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 16'hAAAA};

    reset = 1'b1;
    clear_inputs();
    do_reset();

    // Reset state with no requests.
    @(negedge clock);
    check("rst_stall",  bus.cpu_stall,   0);
    check("rst_ready",  bus.cpu_ready,   0);
    check("rst_gnt",    bus.host_gnt,    0);
    check("rst_rvalid", bus.host_rvalid, 0);
    check("rst_wren",   bus.mem_wren,    0);
    check("rst_addr",   bus.mem_addr,    0);
    check("rst_rdata",  bus.cpu_rdata,   0);
    check("rst_state",  dbg_state,       IDLE);

    // Single-cycle grant decisions from a freshly reset IDLE.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.cpu_req = vecs[i].cpu_req;   bus.cpu_we = vecs[i].cpu_we;
      bus.cpu_addr = vecs[i].cpu_addr; bus.cpu_wdata = vecs[i].cpu_wdata;
      bus.host_req = vecs[i].host_req; bus.host_we = vecs[i].host_we;
      bus.host_addr = vecs[i].host_addr; bus.host_wdata = vecs[i].host_wdata;
      @(negedge clock);
      check({vecs[i].name, "_stall"}, bus.cpu_stall, vecs[i].exp_stall);
      check({vecs[i].name, "_ready"}, bus.cpu_ready, vecs[i].exp_ready);
      check({vecs[i].name, "_gnt"},   bus.host_gnt,  vecs[i].exp_gnt);
      check({vecs[i].name, "_wren"},  bus.mem_wren,  vecs[i].exp_wren);
      check({vecs[i].name, "_addr"},  bus.mem_addr,  vecs[i].exp_addr);
      if (vecs[i].exp_wren) check({vecs[i].name, "_wdata"}, bus.mem_wdata, vecs[i].exp_wdata);
      tick();
      clear_inputs();
      tick();
      tick();
    end

    // Host writes 77 to addr 5, CPU lw addr 5: one stall, then ready with 77.
    do_reset();
    host_drive(1'b1, 8'd5, 16'd77);
    @(negedge clock);
    check("hw5_gnt",  bus.host_gnt, 1);
    check("hw5_wren", bus.mem_wren, 1);
    tick();
    clear_inputs();
    cpu_drive(1'b0, 8'd5, 16'd0);
    @(negedge clock);
    check("lw5_stall", bus.cpu_stall, 1);
    check("lw5_ready", bus.cpu_ready, 0);
    check("lw5_wren",  bus.mem_wren,  0);
    tick();
    @(negedge clock);
    check("lw5_d_stall", bus.cpu_stall, 0);
    check("lw5_d_ready", bus.cpu_ready, 1);
    check("lw5_d_rdata", bus.cpu_rdata, 16'd77);
    check("lw5_d_wren",  bus.mem_wren,  0);
    tick();
    clear_inputs();

    // CPU sw 1234 to addr 9 without host, then host reads it back.
    cpu_drive(1'b1, 8'd9, 16'h1234);
    @(negedge clock);
    check("sw9_stall", bus.cpu_stall, 0);
    check("sw9_ready", bus.cpu_ready, 1);
    tick();
    clear_inputs();
    host_drive(1'b0, 8'd9, 16'd0);
    @(negedge clock);
    check("hr9_gnt",  bus.host_gnt, 1);
    check("hr9_wren", bus.mem_wren, 0);
    tick();
    clear_inputs();
    @(negedge clock);
    check("hr9_rvalid", bus.host_rvalid, 1);
    check("hr9_rdata",  bus.host_rdata,  16'h1234);
    check("hr9_wren",   bus.mem_wren,    0);
    tick();

    // Host read held while CPU issues lw continuously: host wins on the 5th cycle.
    host_drive(1'b0, 8'd9, 16'd0);
    cpu_drive(1'b0, 8'd5, 16'd0);
    gnt_cycle = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (bus.host_gnt) begin
        gnt_cycle = k;
        check("starve_cpu_stall", bus.cpu_stall, 1);
        check("starve_cpu_ready", bus.cpu_ready, 0);
        break;
      end
      tick();
    end
    check("starve_gnt_cycle", gnt_cycle, 4);
    tick();
    bus.host_req = 1'b0;
    @(negedge clock);
    check("starve_rvalid", bus.host_rvalid, 1);
    check("starve_rdata",  bus.host_rdata,  16'h1234);
    check("starve_stall",  bus.cpu_stall,   1);
    tick();
    @(negedge clock);
    check("after_host_cpu_stall", bus.cpu_stall, 1);
    tick();
    @(negedge clock);
    check("after_host_cpu_ready", bus.cpu_ready, 1);
    check("after_host_cpu_rdata", bus.cpu_rdata, 16'd77);
    tick();
    clear_inputs();

    // Simultaneous requests with empty starve count: CPU wins, count becomes 1.
    do_reset();
    cpu_drive(1'b0, 8'd1, 16'd0);
    host_drive(1'b0, 8'd2, 16'd0);
    @(negedge clock);
    check("tie_gnt",   bus.host_gnt,  0);
    check("tie_stall", bus.cpu_stall, 1);
    check("tie_addr",  bus.mem_addr,  8'd1);
    tick();
    @(negedge clock);
    check("tie_starve_cnt", dut.starve_q, 1);
    tick();
    clear_inputs();

    // Reset during the CPU read-data cycle drops the read.
    do_reset();
    cpu_drive(1'b0, 8'd5, 16'd0);
    @(negedge clock);
    check("rrd_stall", bus.cpu_stall, 1);
    tick();
    reset = 1'b1;
    @(negedge clock);
    check("rrd_ready_in_reset", bus.cpu_ready, 0);
    tick();
    reset = 1'b0;
    clear_inputs();
    @(negedge clock);
    check("rrd_state",  dbg_state,       IDLE);
    check("rrd_ready",  bus.cpu_ready,   0);
    check("rrd_rvalid", bus.host_rvalid, 0);
    check("rrd_wren",   bus.mem_wren,    0);

`ifdef DMEM_ARB_STATS_EN
    // Three loads and two host grants.
    do_reset();
    for (int j = 0; j < 3; j++) begin
      cpu_drive(1'b0, 8'(j), 16'd0);
      tick();
      clear_inputs();
      tick();
    end
    for (int j = 0; j < 2; j++) begin
      host_drive(1'b1, 8'(40 + j), 16'(j));
      tick();
      clear_inputs();
      tick();
    end
    @(negedge clock);
    check("stat_stall_cnt", stat_stall_cnt, 16'd3);
    check("stat_host_cnt",  stat_host_cnt,  16'd2);
`endif

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
